// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo controller: FSM state encoding,
// default sizing constants and the byte width used on the RX/TX interfaces.
package uart_pkg;

  localparam int UART_BYTE_W          = 8;
  localparam int UART_DEF_DEPTH       = 128;
  localparam int UART_DEF_IDLE_CYCLES = 100;
  // Gap counter width covers IDLE_CYCLES up to 65535.
  localparam int UART_GAP_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COLLECT   = 2'd1,
    ST_LAUNCH    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } echo_state_t;

endpackage

// File: rtl/uart_echo_fifo.sv
// Echo byte buffer: synchronous FIFO with registered read/write pointers and
// an occupancy count. Pointers wrap modulo DEPTH (power of two), so full and
// empty are derived from the count alone. A push while full is accepted only
// when a pop happens in the same cycle, keeping the count unchanged.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_DEF_DEPTH,
  parameter int DATA_W = UART_BYTE_W
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_full;
  logic              w_pop_ok;

  assign w_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_push_ok = i_push && (!w_full || w_pop_ok);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Pointer and occupancy bookkeeping; simultaneous push and pop cancel.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({o_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; data is not reset, validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (o_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// UART echo controller. Buffers received bytes and, once the RX line has been
// quiet for IDLE_CYCLES clock cycles, replays the whole buffer to the UART
// transmitter one byte per tx_done_i handshake. Bytes that arrive while a
// burst is being replayed join the same burst without a new quiet gap.
// Optional feature macro: UART_ECHO_OVF_CNT_EN adds ovf_cnt_o, a saturating
// count of dropped bytes.
module uart_echo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH       = UART_DEF_DEPTH,
  parameter int IDLE_CYCLES = UART_DEF_IDLE_CYCLES
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    rx_dv_i,
  input  logic [UART_BYTE_W-1:0]  rx_byte_i,
  output logic                    tx_dv_o,
  output logic [UART_BYTE_W-1:0]  tx_byte_o,
  input  logic                    tx_active_i,
  input  logic                    tx_done_i,
  output logic [$clog2(DEPTH):0]  fifo_count_o,
  output logic                    overflow_o,
  output logic                    busy_o
`ifdef UART_ECHO_OVF_CNT_EN
  ,
  output logic [7:0]              ovf_cnt_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [UART_GAP_W-1:0] GAP_LAST = UART_GAP_W'(IDLE_CYCLES - 1);

  echo_state_t            r_state;
  echo_state_t            w_next_state;
  logic [UART_GAP_W-1:0]  r_gap;
  logic                   r_overflow;
  logic                   w_tx_dv;
  logic                   w_pop;
  logic                   w_push_ok;
  logic                   w_drop;
  logic                   w_fifo_empty;
  logic [CW-1:0]          w_fifo_count;
  logic [CW-1:0]          w_count_post;
  logic [UART_BYTE_W-1:0] w_head;

  uart_echo_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (UART_BYTE_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .i_push    (rx_dv_i),
    .i_data    (rx_byte_i),
    .i_pop     (w_pop),
    .o_data    (w_head),
    .o_count   (w_fifo_count),
    .o_empty   (w_fifo_empty),
    .o_push_ok (w_push_ok)
  );

  assign w_drop = rx_dv_i && !w_push_ok;

  // Occupancy as it will be after this cycle's push/pop settle.
  always_comb begin
    w_count_post = w_fifo_count;
    if (w_push_ok && !w_pop)      w_count_post = w_fifo_count + CW'(1);
    else if (!w_push_ok && w_pop) w_count_post = w_fifo_count - CW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_dv_i) w_next_state = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (rx_dv_i)                w_next_state = ST_COLLECT;
        else if (r_gap == GAP_LAST) w_next_state = w_fifo_empty ? ST_IDLE : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        // An empty FIFO cannot occur here; fall back to IDLE defensively.
        if (w_fifo_empty) w_next_state = ST_IDLE;
        else if (w_tx_dv) w_next_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done_i) w_next_state = (w_count_post != '0) ? ST_LAUNCH : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: launch pulse with same-cycle pop, and busy indication.
  always_comb begin
    w_tx_dv = (r_state == ST_LAUNCH) && !tx_active_i && !w_fifo_empty;
    w_pop   = w_tx_dv;
    busy_o  = (r_state != ST_IDLE);
  end

  assign tx_dv_o      = w_tx_dv;
  assign tx_byte_o    = w_tx_dv ? w_head : '0;
  assign fifo_count_o = w_fifo_count;
  assign overflow_o   = r_overflow;

  // RX quiet-gap timer: restarts on each received byte before a burst.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_gap <= '0;
    end else if (rx_dv_i && (r_state == ST_IDLE || r_state == ST_COLLECT)) begin
      r_gap <= '0;
    end else if (r_state == ST_COLLECT && r_gap != GAP_LAST) begin
      r_gap <= r_gap + UART_GAP_W'(1);
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifdef UART_ECHO_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Dropped-byte counter, saturating at 255.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    r_ovf_cnt <= '0;
    else if (w_drop) r_ovf_cnt <= sat_inc8(r_ovf_cnt);
  end

  assign ovf_cnt_o = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Bench for uart_echo_ctrl (DEPTH=4, IDLE_CYCLES=100). Echoed bytes are
// checked against a queue filled as RX bytes are driven; latency, burst,
// overflow and reset behaviour are checked with cycle-relative expectations.
module tb_uart_echo_ctrl;

  localparam int DEPTH = 4;
  localparam int IDLE  = 100;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i       = 1'b0;
  logic          rst_n_i     = 1'b1;
  logic          rx_dv_i     = 1'b0;
  logic [7:0]    rx_byte_i   = 8'h00;
  logic          tx_active_i = 1'b0;
  logic          tx_done_i   = 1'b0;
  logic          tx_dv_o;
  logic [7:0]    tx_byte_o;
  logic [CW-1:0] fifo_count_o;
  logic          overflow_o;
  logic          busy_o;
`ifdef UART_ECHO_OVF_CNT_EN
  logic [7:0]    ovf_cnt_o;
`endif

  uart_echo_ctrl #(
    .DEPTH       (DEPTH),
    .IDLE_CYCLES (IDLE)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .rx_dv_i      (rx_dv_i),
    .rx_byte_i    (rx_byte_i),
    .tx_dv_o      (tx_dv_o),
    .tx_byte_o    (tx_byte_o),
    .tx_active_i  (tx_active_i),
    .tx_done_i    (tx_done_i),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o),
    .busy_o       (busy_o)
`ifdef UART_ECHO_OVF_CNT_EN
    ,
    .ovf_cnt_o    (ovf_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int         checks    = 0;
  int         errors    = 0;
  int         cyc_n     = 0;
  int         act_lo    = 0;
  int         act_hi    = 0;
  int         n_pulses  = 0;
  int         pulse_cyc = -1;
  int         m_cnt     = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] b;
    int         act;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, sample at the falling edge.
  task automatic run_cycle(input logic dv, input logic [7:0] b, input logic done);
    rx_dv_i     = dv;
    rx_byte_i   = b;
    tx_done_i   = done;
    tx_active_i = (cyc_n >= act_lo) && (cyc_n < act_hi);
    if (dv && m_cnt < DEPTH) begin
      exp_q.push_back(b);
      m_cnt++;
    end
    @(negedge clk_i);
    if (tx_dv_o === 1'b1) begin
      n_pulses++;
      pulse_cyc = cyc_n;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got byte %0h expected no pulse", tx_byte_o);
      end else begin
        chk("echo_byte", {24'd0, tx_byte_o}, {24'd0, exp_q.pop_front()});
        m_cnt--;
      end
    end
    @(posedge clk_i);
    #1;
    cyc_n++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_pulse(input int budget, input string name);
    int start;
    int k;
    start = n_pulses;
    k = 0;
    while (n_pulses == start && k < budget) begin
      run_cycle(1'b0, 8'h00, 1'b0);
      k++;
    end
    if (n_pulses == start) begin
      checks++;
      errors++;
      $display("FAIL %s: got no tx_dv_o within %0d cycles expected a pulse", name, budget);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_dv"},    {31'd0, tx_dv_o}, 32'd0);
    chk({tag, "_tx_byte"},  {24'd0, tx_byte_o}, 32'd0);
    chk({tag, "_count"},    32'(fifo_count_o), 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow_o}, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy_o}, 32'd0);
`ifdef UART_ECHO_OVF_CNT_EN
    chk({tag, "_ovf_cnt"},  {24'd0, ovf_cnt_o}, 32'd0);
`endif
  endtask

  // Asynchronous reset applied between clock edges; outputs checked before any edge.
  task automatic apply_reset(input string tag);
    rx_dv_i     = 1'b0;
    tx_done_i   = 1'b0;
    tx_active_i = 1'b0;
    rst_n_i     = 1'b0;
    #2;
    check_all_zero(tag);
    repeat (2) begin
      @(posedge clk_i);
      #1;
      cyc_n++;
    end
    rst_n_i = 1'b1;
    exp_q.delete();
    m_cnt  = 0;
    act_lo = 0;
    act_hi = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int   t0;
    int   d;
    int   p0;

    vecs[0] = '{b: 8'h41, act: 0,  lat: 101};
    vecs[1] = '{b: 8'h00, act: 0,  lat: 101};
    vecs[2] = '{b: 8'hFF, act: 0,  lat: 101};
    vecs[3] = '{b: 8'h5A, act: 20, lat: 121};
    vecs[4] = '{b: 8'h3C, act: 1,  lat: 102};

    #1;
    @(posedge clk_i);
    #1;
    apply_reset("por");

    // Single-byte echo latency, with and without a busy transmitter.
    for (int i = 0; i < 5; i++) begin
      t0 = cyc_n;
      p0 = n_pulses;
      idle_n(10);
      act_lo = t0 + 10 + IDLE + 1;
      act_hi = act_lo + vecs[i].act;
      run_cycle(1'b1, vecs[i].b, 1'b0);
      chk($sformatf("vec%0d_busy_collect", i), {31'd0, busy_o}, 32'd1);
      wait_pulse(400, $sformatf("vec%0d_pulse", i));
      chk($sformatf("vec%0d_latency", i), 32'(pulse_cyc - t0), 32'(10 + vecs[i].lat));
      chk($sformatf("vec%0d_busy_wait", i), {31'd0, busy_o}, 32'd1);
      idle_n(3);
      run_cycle(1'b0, 8'h00, 1'b1);
      chk($sformatf("vec%0d_idle_after_done", i), {31'd0, busy_o}, 32'd0);
      chk($sformatf("vec%0d_count", i), 32'(fifo_count_o), 32'd0);
      chk($sformatf("vec%0d_npulses", i), 32'(n_pulses - p0), 32'd1);
      act_lo = 0;
      act_hi = 0;
    end

    // Two bytes, gap restarted by the second; second pulse right after tx_done_i.
    t0 = cyc_n;
    idle_n(10);
    run_cycle(1'b1, 8'h48, 1'b0);
    idle_n(49);
    run_cycle(1'b1, 8'h49, 1'b0);
    wait_pulse(400, "two_first_pulse");
    chk("two_first_cycle", 32'(pulse_cyc - t0), 32'd161);
    idle_n(4);
    d = cyc_n;
    run_cycle(1'b0, 8'h00, 1'b1);
    wait_pulse(10, "two_second_pulse");
    chk("two_second_cycle", 32'(pulse_cyc - d), 32'd1);
    idle_n(2);
    run_cycle(1'b0, 8'h00, 1'b1);
    chk("two_idle", {31'd0, busy_o}, 32'd0);

    // Byte arriving during WAIT_DONE joins the burst with no quiet gap.
    idle_n(10);
    run_cycle(1'b1, 8'h77, 1'b0);
    wait_pulse(400, "wd_first_pulse");
    run_cycle(1'b0, 8'h00, 1'b0);
    run_cycle(1'b1, 8'h55, 1'b0);
    chk("wd_busy", {31'd0, busy_o}, 32'd1);
    chk("wd_count", 32'(fifo_count_o), 32'd1);
    d = cyc_n;
    run_cycle(1'b0, 8'h00, 1'b1);
    wait_pulse(5, "wd_second_pulse");
    chk("wd_second_cycle", 32'(pulse_cyc - d), 32'd1);
    idle_n(2);
    run_cycle(1'b0, 8'h00, 1'b1);
    chk("wd_idle", {31'd0, busy_o}, 32'd0);

    // Overflow: six bytes into a 4-entry buffer with no drain.
    idle_n(5);
    p0 = n_pulses;
    for (int k = 0; k < 6; k++) begin
      run_cycle(1'b1, 8'hC0 + 8'(k), 1'b0);
      if (k == 3) chk("ovf_flag_before_drop", {31'd0, overflow_o}, 32'd0);
      if (k == 4) chk("ovf_flag_after_drop", {31'd0, overflow_o}, 32'd1);
    end
    chk("ovf_count_full", 32'(fifo_count_o), 32'd4);
    chk("ovf_flag", {31'd0, overflow_o}, 32'd1);
`ifdef UART_ECHO_OVF_CNT_EN
    chk("ovf_cnt", {24'd0, ovf_cnt_o}, 32'd2);
`endif
    for (int k = 0; k < 4; k++) begin
      wait_pulse(400, "ovf_drain_pulse");
      idle_n(2);
      run_cycle(1'b0, 8'h00, 1'b1);
    end
    chk("ovf_drain_npulses", 32'(n_pulses - p0), 32'd4);
    chk("ovf_drain_idle", {31'd0, busy_o}, 32'd0);
    idle_n(150);
    chk("ovf_no_extra", 32'(n_pulses - p0), 32'd4);
    chk("ovf_sticky", {31'd0, overflow_o}, 32'd1);

    // Reset mid-burst with three bytes still buffered.
    apply_reset("rst_clear");
    idle_n(5);
    for (int k = 0; k < 4; k++) run_cycle(1'b1, 8'h10 + 8'(k), 1'b0);
    wait_pulse(400, "mid_first_pulse");
    chk("mid_count", 32'(fifo_count_o), 32'd3);
    chk("mid_busy", {31'd0, busy_o}, 32'd1);
    apply_reset("mid_rst");
    p0 = n_pulses;
    idle_n(300);
    chk("mid_no_pulse", 32'(n_pulses - p0), 32'd0);
    chk("mid_idle", {31'd0, busy_o}, 32'd0);
    t0 = cyc_n;
    run_cycle(1'b1, 8'h99, 1'b0);
    wait_pulse(400, "mid_resume_pulse");
    chk("mid_resume_latency", 32'(pulse_cyc - t0), 32'(IDLE + 1));
    run_cycle(1'b0, 8'h00, 1'b1);
    chk("mid_resume_idle", {31'd0, busy_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
